// File: rtl/std_sdiv_pkg.sv
// Shared types and sizing helpers for the iterative signed divider.
package std_sdiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sdiv_state_t;

    function automatic int unsigned sdiv_cnt_w(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/std_sdiv_step.sv
// One restoring shift-subtract iteration on unsigned magnitudes.
module std_sdiv_step #(
    parameter int unsigned width = 32
) (
    input  logic [width:0]   i_rem,
    input  logic [width-1:0] i_dividend,
    input  logic [width-1:0] i_divisor,
    output logic [width:0]   o_rem,
    output logic [width-1:0] o_dividend
);

    logic [width:0] w_shift;
    logic [width:0] w_divisor;

    // The remainder never exceeds the divisor, so its top bit drops off the shift.
    assign w_shift   = (width + 1)'({i_rem, i_dividend[width-1]});
    assign w_divisor = {1'b0, i_divisor};

    always_comb begin
        o_rem      = w_shift;
        o_dividend = {i_dividend[width-2:0], 1'b0};
        if (w_shift >= w_divisor) begin
            o_rem         = w_shift - w_divisor;
            o_dividend[0] = 1'b1;
        end
    end

endmodule

// File: rtl/std_sdiv_pipe.sv
// Multi-cycle signed divider (quotient + remainder) under a go/done handshake.
// Optional STD_SDIV_PIPE_ZERO_FASTPATH_EN skips the iterations for a zero operand.
module std_sdiv_pipe
    import std_sdiv_pkg::*;
#(
    parameter int unsigned width = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic [width-1:0] left,
    input  logic [width-1:0] right,
    output logic [width-1:0] out_quotient,
    output logic [width-1:0] out_remainder,
    output logic             done
);

    localparam int unsigned CW = sdiv_cnt_w(width);
    localparam logic [CW-1:0] LAST = CW'(width - 1);

    sdiv_state_t      r_state, w_state_nxt;
    logic [CW-1:0]    r_cnt, w_cnt_nxt;
    logic [width:0]   r_rem, w_rem_nxt;
    logic [width-1:0] r_dvd, w_dvd_nxt;
    logic [width-1:0] r_dsr, w_dsr_nxt;
    logic [width-1:0] r_left, w_left_nxt;
    logic             r_sign_q, w_sign_q_nxt;
    logic             r_sign_r, w_sign_r_nxt;
    logic             r_den_zero, w_den_zero_nxt;
    logic [width-1:0] r_quo_out, w_quo_out_nxt;
    logic [width-1:0] r_rem_out, w_rem_out_nxt;
    logic             r_done, w_done_nxt;

    logic [width-1:0] w_abs_l, w_abs_r;
    logic [width:0]   w_step_rem;
    logic [width-1:0] w_step_dvd;

    assign w_abs_l = left[width-1]  ? -left  : left;
    assign w_abs_r = right[width-1] ? -right : right;

    std_sdiv_step #(.width(width)) u_step (
        .i_rem      (r_rem),
        .i_dividend (r_dvd),
        .i_divisor  (r_dsr),
        .o_rem      (w_step_rem),
        .o_dividend (w_step_dvd)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_rem      <= '0;
            r_dvd      <= '0;
            r_dsr      <= '0;
            r_left     <= '0;
            r_sign_q   <= 1'b0;
            r_sign_r   <= 1'b0;
            r_den_zero <= 1'b0;
            r_quo_out  <= '0;
            r_rem_out  <= '0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_rem      <= w_rem_nxt;
            r_dvd      <= w_dvd_nxt;
            r_dsr      <= w_dsr_nxt;
            r_left     <= w_left_nxt;
            r_sign_q   <= w_sign_q_nxt;
            r_sign_r   <= w_sign_r_nxt;
            r_den_zero <= w_den_zero_nxt;
            r_quo_out  <= w_quo_out_nxt;
            r_rem_out  <= w_rem_out_nxt;
            r_done     <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_rem_nxt      = r_rem;
        w_dvd_nxt      = r_dvd;
        w_dsr_nxt      = r_dsr;
        w_left_nxt     = r_left;
        w_sign_q_nxt   = r_sign_q;
        w_sign_r_nxt   = r_sign_r;
        w_den_zero_nxt = r_den_zero;
        w_quo_out_nxt  = r_quo_out;
        w_rem_out_nxt  = r_rem_out;
        w_done_nxt     = 1'b0;
        case (r_state)
            IDLE: begin
                if (go) begin
                    w_dvd_nxt      = w_abs_l;
                    w_dsr_nxt      = w_abs_r;
                    w_left_nxt     = left;
                    w_sign_q_nxt   = left[width-1] ^ right[width-1];
                    w_sign_r_nxt   = left[width-1];
                    w_den_zero_nxt = (right == '0);
                    w_rem_nxt      = '0;
                    w_cnt_nxt      = '0;
                    w_state_nxt    = RUN;
`ifdef STD_SDIV_PIPE_ZERO_FASTPATH_EN
                    if ((left == '0) || (right == '0)) begin
                        w_state_nxt = DONE;
                    end
`endif
                end
            end
            RUN: begin
                if (!go) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_rem_nxt = w_step_rem;
                    w_dvd_nxt = w_step_dvd;
                    w_cnt_nxt = r_cnt + CW'(1);
                    if (r_cnt == LAST) begin
                        w_state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                // Divide-by-zero results are forced here, independent of the datapath.
                if (r_den_zero) begin
                    w_quo_out_nxt = '1;
                    w_rem_out_nxt = r_left;
                end else begin
                    w_quo_out_nxt = r_sign_q ? -r_dvd : r_dvd;
                    w_rem_out_nxt = r_sign_r ? -r_rem[width-1:0] : r_rem[width-1:0];
                end
                w_done_nxt  = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign out_quotient  = r_quo_out;
    assign out_remainder = r_rem_out;
    assign done          = r_done;

endmodule
